// File: rtl/jace_kbd_pkg.sv
// Shared types and constants for the Jupiter Ace PS/2 keyboard adapter:
// decoder states, PS/2 prefix bytes and matrix geometry.
package jace_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXTBRK
  } kbd_state_t;

  localparam logic [7:0] PREFIX_E0    = 8'hE0;
  localparam logic [7:0] PREFIX_F0    = 8'hF0;
  localparam logic [7:0] SC_BACKSPACE = 8'h66;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;
  localparam int ROW_W    = 3;
  localparam int COL_W    = 3;

endpackage

// File: rtl/jace_kbd_map.sv
// Combinational PS/2 set-2 scancode to Ace matrix position lookup.
// Both shift keys share row 0 col 0; LCtrl stands in for Symbol Shift.
module jace_kbd_map
  import jace_kbd_pkg::*;
(
  input  logic [7:0]       code,
  output logic             hit,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    hit = 1'b1;
    row = '0;
    col = '0;
    case (code)
      8'h12, 8'h59: begin row = 3'd0; col = 3'd0; end
      8'h14:        begin row = 3'd0; col = 3'd1; end
      8'h1A:        begin row = 3'd0; col = 3'd2; end
      8'h22:        begin row = 3'd0; col = 3'd3; end
      8'h21:        begin row = 3'd0; col = 3'd4; end
      8'h1C:        begin row = 3'd1; col = 3'd0; end
      8'h1B:        begin row = 3'd1; col = 3'd1; end
      8'h23:        begin row = 3'd1; col = 3'd2; end
      8'h2B:        begin row = 3'd1; col = 3'd3; end
      8'h34:        begin row = 3'd1; col = 3'd4; end
      8'h15:        begin row = 3'd2; col = 3'd0; end
      8'h1D:        begin row = 3'd2; col = 3'd1; end
      8'h24:        begin row = 3'd2; col = 3'd2; end
      8'h2D:        begin row = 3'd2; col = 3'd3; end
      8'h2C:        begin row = 3'd2; col = 3'd4; end
      8'h16:        begin row = 3'd3; col = 3'd0; end
      8'h1E:        begin row = 3'd3; col = 3'd1; end
      8'h26:        begin row = 3'd3; col = 3'd2; end
      8'h25:        begin row = 3'd3; col = 3'd3; end
      8'h2E:        begin row = 3'd3; col = 3'd4; end
      8'h45:        begin row = 3'd4; col = 3'd0; end
      8'h46:        begin row = 3'd4; col = 3'd1; end
      8'h3E:        begin row = 3'd4; col = 3'd2; end
      8'h3D:        begin row = 3'd4; col = 3'd3; end
      8'h36:        begin row = 3'd4; col = 3'd4; end
      8'h4D:        begin row = 3'd5; col = 3'd0; end
      8'h44:        begin row = 3'd5; col = 3'd1; end
      8'h43:        begin row = 3'd5; col = 3'd2; end
      8'h3C:        begin row = 3'd5; col = 3'd3; end
      8'h35:        begin row = 3'd5; col = 3'd4; end
      8'h5A:        begin row = 3'd6; col = 3'd0; end
      8'h4B:        begin row = 3'd6; col = 3'd1; end
      8'h42:        begin row = 3'd6; col = 3'd2; end
      8'h3B:        begin row = 3'd6; col = 3'd3; end
      8'h33:        begin row = 3'd6; col = 3'd4; end
      8'h29:        begin row = 3'd7; col = 3'd0; end
      8'h3A:        begin row = 3'd7; col = 3'd1; end
      8'h31:        begin row = 3'd7; col = 3'd2; end
      8'h32:        begin row = 3'd7; col = 3'd3; end
      8'h2A:        begin row = 3'd7; col = 3'd4; end
      default:      hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/jace_ps2_keyboard.sv
// PS/2 keyboard to Jupiter Ace 8x5 matrix adapter: synchroniser, clock filter,
// frame receiver, make/break decoder and column readback. Option: JACE_KBD_PARITY_EN.
module jace_ps2_keyboard
  import jace_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] rows_n,
  output logic [4:0] kbdcols,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, fall, data_bit;
  logic [FW-1:0] filt_cnt;

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level flips only after FILTER_LEN samples disagree with it in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      data_bit <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
        data_bit <= data_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] idle_cnt;
`ifdef JACE_KBD_PARITY_EN
  logic par_bit, par_err_q;
`endif

  // bit_cnt: 0 = idle, 1..8 = data bits, 9 = parity, 10 = stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
`ifdef JACE_KBD_PARITY_EN
      par_bit   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef JACE_KBD_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_bit) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {data_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end else if (bit_cnt == 4'd9) begin
`ifdef JACE_KBD_PARITY_EN
          par_bit <= data_bit;
`endif
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          bit_cnt <= '0;
          if (data_bit) begin
`ifdef JACE_KBD_PARITY_EN
            if (^{shreg, par_bit}) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              par_err_q <= 1'b1;
            end
`else
            rx_byte  <= shreg;
            rx_valid <= 1'b1;
`endif
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TO_MAX) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

`ifdef JACE_KBD_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  logic             map_hit;
  logic [ROW_W-1:0] map_row;
  logic [COL_W-1:0] map_col;

  jace_kbd_map u_map (
    .code (rx_byte),
    .hit  (map_hit),
    .row  (map_row),
    .col  (map_col)
  );

  kbd_state_t state, state_nx;
  logic       key_set, key_clr, bksp_set, bksp_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    key_set  = 1'b0;
    key_clr  = 1'b0;
    bksp_set = 1'b0;
    bksp_clr = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if      (rx_byte == PREFIX_F0)    state_nx = ST_BRK;
          else if (rx_byte == PREFIX_E0)    state_nx = ST_EXT;
          else if (rx_byte == SC_BACKSPACE) bksp_set = 1'b1;
          else                              key_set  = map_hit;
        end
        ST_BRK: begin
          state_nx = ST_IDLE;
          if (rx_byte == SC_BACKSPACE) bksp_clr = 1'b1;
          else                         key_clr  = map_hit;
        end
        ST_EXT:  state_nx = (rx_byte == PREFIX_F0) ? ST_EXTBRK : ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix;
  logic                              bksp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
      bksp   <= 1'b0;
    end else begin
      if (key_set) matrix[map_row][map_col] <= 1'b1;
      if (key_clr) matrix[map_row][map_col] <= 1'b0;
      if (bksp_set) bksp <= 1'b1;
      if (bksp_clr) bksp <= 1'b0;
    end
  end

  // Backspace on the Ace is Caps Shift (row 0 col 0) plus 0 (row 4 col 0).
  logic [NUM_COLS-1:0] col_hit;
  always_comb begin
    col_hit = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows_n[r]) begin
        col_hit = col_hit | matrix[r];
        if (bksp && (r == 0 || r == 4)) col_hit[0] = 1'b1;
      end
    end
    kbdcols = ~col_hit;
  end

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Self-checking bench: PS/2 frames driven into the adapter, received bytes checked
// by a scoreboard monitor, matrix readback checked against a key-level model.
module tb_jace_ps2_keyboard;

  localparam int FILT = 4;
  localparam int TMO  = 1000;
  localparam int HALF = 12;
`ifdef JACE_KBD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rows_n = 8'hFF;
  logic [4:0] kbdcols;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       parity_err;

  always #5 clk = ~clk;

  jace_ps2_keyboard #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rows_n     (rows_n),
    .kbdcols    (kbdcols),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .parity_err (parity_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference key model: pressed flags indexed row*5+col, plus pending prefixes.
  bit         pressed[40];
  bit         bksp_m;
  bit         pfx_brk, pfx_ext;
  logic [7:0] key_codes[40] = '{
    8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [7:0] code);
    if (code == 8'h59) return 0;
    for (int i = 0; i < 40; i++) if (key_codes[i] == code) return i;
    return -1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    idx = key_index(b);
    if (pfx_ext) begin
      if (!pfx_brk && b == 8'hF0) pfx_brk = 1'b1;
      else begin pfx_ext = 1'b0; pfx_brk = 1'b0; end
    end else if (pfx_brk) begin
      pfx_brk = 1'b0;
      if (b == 8'h66) bksp_m = 1'b0;
      else if (idx >= 0) pressed[idx] = 1'b0;
    end else if (b == 8'hF0) pfx_brk = 1'b1;
    else if (b == 8'hE0) pfx_ext = 1'b1;
    else if (b == 8'h66) bksp_m = 1'b1;
    else if (idx >= 0) pressed[idx] = 1'b1;
  endfunction

  function automatic logic [4:0] model_cols(input logic [7:0] rn);
    logic [4:0] cols;
    cols = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      if (!rn[r]) begin
        for (int c = 0; c < 5; c++) if (pressed[r*5+c]) cols[c] = 1'b0;
        if (bksp_m && (r == 0 || r == 4)) cols[0] = 1'b0;
      end
    end
    return cols;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
    bksp_m  = 1'b0;
    pfx_brk = 1'b0;
    pfx_ext = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int nbits = 11);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11 && !bad_stop) begin
      if (bad_par && PAR_EN) exp_q.push_back('{is_err: 1'b1, code: b});
      else begin
        exp_q.push_back('{is_err: 1'b0, code: b});
        model_byte(b);
      end
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] code, input bit ext, input bit rel,
                          input bit bad_par = 1'b0);
    if (ext) send_frame(8'hE0);
    if (rel) send_frame(8'hF0);
    send_frame(code, bad_par);
  endtask

  task automatic check_cols(input string name, input logic [7:0] rn, input logic [4:0] exp);
    rows_n = rn;
    #1;
    check(name, kbdcols, exp);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (rx_valid || parity_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rx_valid=%0b parity_err=%0b rx_byte=%0h, none expected",
                 rx_valid, parity_err, rx_byte);
      end else begin
        e = exp_q.pop_front();
        check("rx_kind", {30'd0, rx_valid, parity_err}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) check("rx_byte", {24'd0, rx_byte}, {24'd0, e.code});
      end
    end
  end

  initial begin
    int  k;
    bit  rel, ext, bad;
    logic [7:0] code, rn;

    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check_cols("reset_cols", 8'h00, 5'b11111);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    send_key(8'h1C, 1'b0, 1'b0);
    check_cols("a_press", 8'hFD, 5'b11110);
    send_key(8'h1C, 1'b0, 1'b1);
    check_cols("a_release", 8'hFD, 5'b11111);

    send_key(8'h1C, 1'b0, 1'b0);
    send_key(8'h15, 1'b0, 1'b0);
    check_cols("aq_rows_f9", 8'hF9, 5'b11110);
    check_cols("aq_rows_fb", 8'hFB, 5'b11110);
    check_cols("aq_rows_fe", 8'hFE, 5'b11111);
    send_key(8'h1C, 1'b0, 1'b0);
    check_cols("a_repress", 8'hFD, 5'b11110);
    send_key(8'h1C, 1'b0, 1'b1);
    send_key(8'h15, 1'b0, 1'b1);
    send_key(8'h15, 1'b0, 1'b1);
    check_cols("aq_released", 8'h00, 5'b11111);

    send_key(8'h66, 1'b0, 1'b0);
    check_cols("bksp_row0", 8'hFE, 5'b11110);
    check_cols("bksp_row4", 8'hEF, 5'b11110);
    send_key(8'h66, 1'b0, 1'b1);
    check_cols("bksp_rel_row0", 8'hFE, 5'b11111);
    check_cols("bksp_rel_row4", 8'hEF, 5'b11111);

    send_key(8'h29, 1'b0, 1'b0, 1'b1);
    check_cols("space_bad_parity", 8'h7F, PAR_EN ? 5'b11111 : 5'b11110);
    if (!PAR_EN) send_key(8'h29, 1'b0, 1'b1);

    send_frame(8'h1C, 1'b0, 1'b1);
    check_cols("bad_stop", 8'hFD, 5'b11111);

    send_frame(8'h5A, 1'b0, 1'b0, 5);
    repeat (TMO + 500) @(posedge clk);
    send_frame(8'h5A);
    check_cols("timeout_enter", 8'hBF, 5'b11110);
    send_key(8'h5A, 1'b0, 1'b1);

    send_key(8'h75, 1'b1, 1'b0);
    send_key(8'h75, 1'b1, 1'b1);
    check_cols("extended_none", 8'h00, 5'b11111);

    for (int n = 0; n < 40; n++) begin
      k   = int'($urandom_range(0, 42));
      rel = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      ext = (k == 41);
      code = (k < 40) ? key_codes[k] : (k == 40) ? 8'h66 : (k == 41) ? 8'h75 : 8'h59;
      send_key(code, ext, rel, bad);
      for (int j = 0; j < 2; j++) begin
        rn = 8'($urandom);
        check_cols("random_cols", rn, model_cols(rn));
      end
    end

    send_key(8'h16, 1'b0, 1'b0);
    check_cols("pre_reset_key", 8'hF7, model_cols(8'hF7));
    send_frame(8'h33, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("midreset_rx_byte", {24'd0, rx_byte}, 32'h00);
    check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset_parity_err", {31'd0, parity_err}, 32'd0);
    check_cols("midreset_cols", 8'h00, 5'b11111);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h12);
    check_cols("after_reset_shift", 8'hFE, 5'b11110);
    check_cols("after_reset_all", 8'h00, model_cols(8'h00));

    repeat (20) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
